// File: rtl/exe_muldiv_seq.sv
// -----------------------------------------------------------------------------
// exe_muldiv_seq
//   Iterative unsigned multiply / divide unit that sits beside the EXE-stage
//   ALU. A start request latches the operands, then one bit is processed per
//   cycle (shift-add multiply, restoring divide). The upstream pipeline is held
//   with a stall while the unit works; the result is flagged valid for exactly
//   one cycle together with the latched write-back register address.
//
// Configuration macro:
//   MULDIV_EARLY_OUT_EN - when defined, a multiply finishes as soon as the
//                         remaining multiplier bits are all zero. Results are
//                         identical either way; only latency changes.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous reset, active-high
//   mdi_start      in   request, sampled only in IDLE
//   mdi_op         in   2'b01 MUL, 2'b10 DIVU, others ignored
//   mdi_op1        in   multiplicand / dividend
//   mdi_op2        in   multiplier / divisor
//   mdi_wreg_addr  in   destination register, latched on accept
//   mdi_flush      in   abort the current operation
//   mdo_stall      out  hold upstream stages (combinational)
//   mdo_valid      out  one-cycle result strobe
//   mdo_lo         out  MUL: product low half, DIVU: quotient
//   mdo_hi         out  MUL: product high half, DIVU: remainder
//   mdo_dz         out  divide-by-zero flag, qualified by mdo_valid
//   mdo_wreg_addr  out  latched destination register
// -----------------------------------------------------------------------------
module exe_muldiv_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mdi_start,
    input  logic [1:0]       mdi_op,
    input  logic [WIDTH-1:0] mdi_op1,
    input  logic [WIDTH-1:0] mdi_op2,
    input  logic [3:0]       mdi_wreg_addr,
    input  logic             mdi_flush,
    output logic             mdo_stall,
    output logic             mdo_valid,
    output logic [WIDTH-1:0] mdo_lo,
    output logic [WIDTH-1:0] mdo_hi,
    output logic             mdo_dz,
    output logic [3:0]       mdo_wreg_addr
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_mul;
    // Multiply datapath: multiplicand shifts left, multiplier shifts right, so
    // the partial product is always correctly aligned and can be taken as the
    // final result the moment the remaining multiplier bits run out.
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    // Divide datapath: dividend shifts out of r_quot into r_rem while quotient
    // bits shift in from the right.
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_divisor;
    logic                 r_valid;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_hi;
    logic                 r_dz;
    logic [3:0]           r_wreg;

    logic                 w_accept;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic [WIDTH-1:0]     w_mplier_nxt;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_sub_ok;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quot_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_last;

    // Flush beats start in the same cycle.
    assign w_accept = (r_state == S_IDLE) && mdi_start && !mdi_flush &&
                      ((mdi_op == OP_MUL) || (mdi_op == OP_DIVU));

    // One shift-add step.
    assign w_prod_nxt   = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mplier_nxt = r_mplier >> 1;

    // One restoring-division step. The shifted remainder needs one extra bit;
    // when it is >= divisor the difference always fits back into WIDTH bits.
    assign w_rem_sh   = {r_rem, r_quot[WIDTH-1]};
    assign w_sub_ok   = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nxt  = w_sub_ok ? (w_rem_sh[WIDTH-1:0] - r_divisor) : w_rem_sh[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_sub_ok};

    assign w_cnt_nxt = r_cnt - 1'b1;
    assign w_last    = (w_cnt_nxt == '0) ||
                       (EARLY_OUT && r_is_mul && (w_mplier_nxt == '0));

    // Stall drops in the same cycle as a flush or reset so the pipeline can
    // redirect without waiting for the state register.
    assign mdo_stall = !rst && (w_accept || ((r_state == S_BUSY) && !mdi_flush));
    assign mdo_valid = r_valid && !mdi_flush;
    assign mdo_lo        = r_lo;
    assign mdo_hi        = r_hi;
    assign mdo_dz        = r_dz;
    assign mdo_wreg_addr = r_wreg;

    // NOTE: every register here is written with non-blocking assignments so
    // all state updates see the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_valid   <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_dz      <= 1'b0;
            r_wreg    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (mdi_flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_is_mul  <= (mdi_op == OP_MUL);
                            r_wreg    <= mdi_wreg_addr;
                            r_dz      <= 1'b0;
                            r_cnt     <= CNT_W'(WIDTH);
                            r_prod    <= '0;
                            r_mcand   <= {{WIDTH{1'b0}}, mdi_op1};
                            r_mplier  <= mdi_op2;
                            r_rem     <= '0;
                            r_quot    <= mdi_op1;
                            r_divisor <= mdi_op2;
                            if ((mdi_op == OP_DIVU) && (mdi_op2 == '0)) begin
                                // Divide by zero skips BUSY entirely.
                                r_state <= S_DONE;
                                r_valid <= 1'b1;
                                r_lo    <= '1;
                                r_hi    <= mdi_op1;
                                r_dz    <= 1'b1;
                            end else if (EARLY_OUT && (mdi_op == OP_MUL) && (mdi_op2 == '0)) begin
                                r_state <= S_DONE;
                                r_valid <= 1'b1;
                                r_lo    <= '0;
                                r_hi    <= '0;
                            end else begin
                                r_state <= S_BUSY;
                            end
                        end
                    end
                    S_BUSY: begin
                        r_cnt <= w_cnt_nxt;
                        if (r_is_mul) begin
                            r_prod   <= w_prod_nxt;
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= w_mplier_nxt;
                        end else begin
                            r_rem  <= w_rem_nxt;
                            r_quot <= w_quot_nxt;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b1;
                            if (r_is_mul) begin
                                r_lo <= w_prod_nxt[WIDTH-1:0];
                                r_hi <= w_prod_nxt[2*WIDTH-1:WIDTH];
                            end else begin
                                r_lo <= w_quot_nxt;
                                r_hi <= w_rem_nxt;
                            end
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
